servo_pwm_out: RTL



---
 rtl/servo_pkg.sv | 27 ++
 rtl/servo_cmd_buf.sv | 32 +++
 rtl/servo_pwm_out.sv | 100 ++++++++++
 3 files changed

// File: rtl/servo_pkg.sv
// Shared types and constants for the servo PWM output stage.
// All widths and ramp values are in microseconds on a 15-bit unsigned scale.
package servo_pkg;

    localparam int US_W = 15;

    localparam logic [US_W-1:0] FRAME_TOP     = 15'd20000;
    localparam logic [US_W-1:0] MIN_WIDTH     = 15'd1000;
    localparam logic [US_W-1:0] MAX_WIDTH     = 15'd2000;
    localparam logic [US_W-1:0] NEUTRAL_WIDTH = 15'd1500;

    typedef enum logic [1:0] {
        DISABLED,
        WAIT,
        RUN
    } pwm_state_t;

    function automatic logic [US_W-1:0] clamp_width(input logic [US_W-1:0] w);
        if (w < MIN_WIDTH)
            return MIN_WIDTH;
        else if (w > MAX_WIDTH)
            return MAX_WIDTH;
        else
            return w;
    endfunction

endpackage

// File: rtl/servo_cmd_buf.sv
// One-entry clamp-and-hold buffer for pulse-width commands.
// Accepts while empty; emptied only when the parent commits the entry.
module servo_cmd_buf
    import servo_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cmd_valid,
    input  logic [US_W-1:0] cmd_width,
    input  logic            take,
    output logic            cmd_ready,
    output logic [US_W-1:0] pending,
    output logic            pending_valid
);

    assign cmd_ready = !pending_valid;

    // take only fires with the entry full and a transfer only with it empty,
    // so the two never collide on the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending       <= NEUTRAL_WIDTH;
            pending_valid <= 1'b0;
        end else if (take) begin
            pending_valid <= 1'b0;
        end else if (cmd_valid && cmd_ready) begin
            pending       <= clamp_width(cmd_width);
            pending_valid <= 1'b1;
        end
    end

endmodule

// File: rtl/servo_pwm_out.sv
// Servo PWM pin driver: frame-aligned width commit, enable FSM and frame watchdog.
// The pin goes high at ramp 0 and stays high for cur_width ramp values, one cycle late.
module servo_pwm_out
    import servo_pkg::*;
#(
    parameter int TIMEOUT_FRAMES = 25
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            enable,
    input  logic [US_W-1:0] cnt_val,
    input  logic            cmd_valid,
    input  logic [US_W-1:0] cmd_width,
    output logic            cmd_ready,
    output logic            pwm_out,
    output logic [US_W-1:0] cur_width,
    output logic            frame_start,
    output logic            timeout
);

    localparam int WD_W = $clog2(TIMEOUT_FRAMES + 1);

    pwm_state_t      state, state_next;
    logic [US_W-1:0] prev_cnt;
    logic [US_W-1:0] pending;
    logic [US_W-1:0] cur_width_next;
    logic            pending_valid;
    logic            commit;
    logic            wd_inc;
    logic            wd_fire;
    logic [WD_W-1:0] wd_cnt;

    servo_cmd_buf u_cmd_buf (
        .clk           (clk),
        .rst_n         (rst_n),
        .cmd_valid     (cmd_valid),
        .cmd_width     (cmd_width),
        .take          (commit),
        .cmd_ready     (cmd_ready),
        .pending       (pending),
        .pending_valid (pending_valid)
    );

    // prev_cnt resets to 0, so no frame is seen until the first real wrap.
    assign frame_start = (cnt_val == '0) && (prev_cnt != '0);
    assign commit      = frame_start && pending_valid;
    assign wd_inc      = frame_start && !pending_valid && (state != DISABLED);
    assign wd_fire     = wd_inc && (wd_cnt == WD_W'(TIMEOUT_FRAMES - 1));

    always_comb begin
        state_next     = state;
        cur_width_next = cur_width;
        case (state)
            DISABLED: if (enable) state_next = WAIT;
            WAIT: begin
                if (!enable)          state_next = DISABLED;
                else if (frame_start) state_next = RUN;
            end
            RUN:      if (!enable) state_next = DISABLED;
            default:  state_next = DISABLED;
        endcase
        if (commit)
            cur_width_next = pending;
        else if (wd_fire)
            cur_width_next = NEUTRAL_WIDTH;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= DISABLED;
            prev_cnt  <= '0;
            cur_width <= NEUTRAL_WIDTH;
            pwm_out   <= 1'b0;
        end else begin
            state     <= state_next;
            prev_cnt  <= cnt_val;
            cur_width <= cur_width_next;
            pwm_out   <= (state_next == RUN) && (cnt_val < cur_width_next);
        end
    end

    // Count saturates at TIMEOUT_FRAMES so the fallback fires once per outage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt  <= '0;
            timeout <= 1'b0;
        end else begin
            if (state == DISABLED || commit)
                wd_cnt <= '0;
            else if (wd_inc && wd_cnt != WD_W'(TIMEOUT_FRAMES))
                wd_cnt <= wd_cnt + WD_W'(1);

            if (commit)
                timeout <= 1'b0;
            else if (wd_fire)
                timeout <= 1'b1;
        end
    end

endmodule
